// File: rtl/note_tone_player.sv
// Piano-key square-wave tone generator: latches a key/duration request, plays the
// tone for duration ms, then holds a silent gap before pulsing noteDone.
module note_tone_player #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int COUNT_WIDTH     = 21,
  parameter int DUR_WIDTH       = 12,
  parameter int GAP_MS          = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             key,
  input  logic [DUR_WIDTH-1:0]   duration,
  input  logic                   noteValid,
  input  logic                   stop,
  output logic                   noteReady,
  output logic                   toneOut,
  output logic [COUNT_WIDTH-1:0] halfPeriod,
  output logic                   noteDone
);

  localparam int PRE_CYCLES = CLOCK_FREQUENCY / 1000;
  localparam int PRE_W      = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
  localparam int GAP_W      = $clog2(GAP_MS + 1);
  localparam int MS_W       = (DUR_WIDTH > GAP_W) ? DUR_WIDTH : GAP_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CYCLES - 1);
  localparam logic [MS_W-1:0]  GAP_LAST = MS_W'(GAP_MS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, PLAY, GAP} state_t;

  // Half-periods of the lowest octave (A0..G#1); higher octaves are right shifts.
  function automatic logic [COUNT_WIDTH-1:0] base_hp(input int idx);
    longint mhz;
    case (idx)
      0:       mhz = 27500;
      1:       mhz = 29135;
      2:       mhz = 30868;
      3:       mhz = 32703;
      4:       mhz = 34648;
      5:       mhz = 36708;
      6:       mhz = 38891;
      7:       mhz = 41203;
      8:       mhz = 43654;
      9:       mhz = 46249;
      10:      mhz = 48999;
      default: mhz = 51913;
    endcase
    return COUNT_WIDTH'((longint'(CLOCK_FREQUENCY) * 500) / mhz);
  endfunction

  localparam logic [COUNT_WIDTH-1:0] BASE_HP [12] = '{
    base_hp(0), base_hp(1), base_hp(2), base_hp(3), base_hp(4),  base_hp(5),
    base_hp(6), base_hp(7), base_hp(8), base_hp(9), base_hp(10), base_hp(11)
  };

  state_t                 state_q, state_d;
  logic [6:0]             key_q, key_d;
  logic [DUR_WIDTH-1:0]   dur_q, dur_d;
  logic [COUNT_WIDTH-1:0] hp_q, hp_d;
  logic [COUNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                   tone_q, tone_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [MS_W-1:0]        ms_q, ms_d;
  logic                   done_c;

  logic                   pre_tick;
  logic [MS_W-1:0]        dur_last;
  logic [6:0]             k0;
  logic [2:0]             oct;
  logic [3:0]             idx;
  logic                   key_ok;
  logic [COUNT_WIDTH-1:0] lookup_hp;

  // Octave/semitone split by constant compares and subtracts rather than a divider.
  always_comb begin
    k0     = key_q - 7'd1;
    key_ok = (key_q != 7'd0) && (key_q <= 7'd88);
    oct    = 3'd0;
    idx    = k0[3:0];
    for (int o = 1; o < 8; o++) begin
      if (k0 >= 7'(12 * o)) begin
        oct = 3'(o);
        idx = 4'(k0 - 7'(12 * o));
      end
    end
    lookup_hp = key_ok ? (BASE_HP[idx] >> oct) : '0;
  end

  assign pre_tick = (pre_q == PRE_LAST);
  assign dur_last = MS_W'(dur_q) - MS_W'(1);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dur_d   = dur_q;
    hp_d    = hp_q;
    tcnt_d  = tcnt_q;
    tone_d  = tone_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (noteValid) begin
          key_d   = key;
          dur_d   = duration;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        tcnt_d = '0;
        ms_d   = '0;
        pre_d  = '0;
        tone_d = 1'b0;
        if (stop || (dur_q == '0)) begin
          hp_d    = '0;
          state_d = GAP;
        end else begin
          hp_d    = lookup_hp;
          state_d = PLAY;
        end
      end
      PLAY: begin
        pre_d = pre_tick ? '0 : pre_q + PRE_W'(1);
        if (pre_tick) ms_d = ms_q + MS_W'(1);
        if (hp_q != '0) begin
          if (tcnt_q == hp_q - COUNT_WIDTH'(1)) begin
            tone_d = ~tone_q;
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + COUNT_WIDTH'(1);
          end
        end
        // Abort and natural end share one exit so a coincident stop is a single transition.
        if (stop || (pre_tick && (ms_q == dur_last))) begin
          state_d = GAP;
          tone_d  = 1'b0;
          hp_d    = '0;
          tcnt_d  = '0;
          pre_d   = '0;
          ms_d    = '0;
        end
      end
      GAP: begin
        pre_d = pre_tick ? '0 : pre_q + PRE_W'(1);
        if (pre_tick) begin
          if (ms_q == GAP_LAST) begin
            state_d = IDLE;
            done_c  = 1'b1;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      dur_q   <= '0;
      hp_q    <= '0;
      tcnt_q  <= '0;
      tone_q  <= 1'b0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dur_q   <= dur_d;
      hp_q    <= hp_d;
      tcnt_q  <= tcnt_d;
      tone_q  <= tone_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
    end
  end

  assign noteReady  = (state_q == IDLE);
  assign toneOut    = tone_q;
  assign halfPeriod = hp_q;
  assign noteDone   = done_c;

endmodule

// File: tb/tb_note_tone_player.sv
// Scoreboarded bench: a small-clock instance plays whole notes; a default-parameter
// instance checks the spec half-period table and mid-note reset.
module tb_note_tone_player;

  localparam int CF = 100000;  // 100 cycles per ms keeps notes short

  logic        clk = 1'b0;
  logic        rst, valid, stop;
  logic [6:0]  key;
  logic [11:0] dur;
  logic        ready, tone, done;
  logic [20:0] hp;

  logic        rst2, valid2;
  logic [6:0]  key2;
  logic [11:0] dur2;
  logic        stop2;
  logic        ready2, tone2, done2;
  logic [20:0] hp2;

  note_tone_player #(.CLOCK_FREQUENCY(CF)) dut (
    .clock(clk), .reset(rst), .key(key), .duration(dur), .noteValid(valid), .stop(stop),
    .noteReady(ready), .toneOut(tone), .halfPeriod(hp), .noteDone(done)
  );

  note_tone_player dut2 (
    .clock(clk), .reset(rst2), .key(key2), .duration(dur2), .noteValid(valid2), .stop(stop2),
    .noteReady(ready2), .toneOut(tone2), .halfPeriod(hp2), .noteDone(done2)
  );

  typedef struct {
    int hp;
    int rises;
    int first;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: measures each note between acceptance and noteDone, then scores it.
  initial begin
    int   acc_cyc, rises, first_off, hp_seen;
    bit   in_note, prev_tone, ready_chk;
    exp_t e;
    in_note = 0; prev_tone = 0; ready_chk = 0;
    acc_cyc = 0; rises = 0; first_off = -1; hp_seen = -1;
    forever begin
      @(negedge clk);
      if (ready_chk) begin
        chk("ready_after_done", ready, 1);
        ready_chk = 0;
      end
      if (rst) begin
        in_note = 0;
      end else begin
        if (in_note) begin
          if (cyc == acc_cyc + 2) hp_seen = int'(hp);
          if (tone && !prev_tone) begin
            rises++;
            if (first_off < 0) first_off = cyc - acc_cyc;
          end
        end
        if (done) begin
          if (!in_note || sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_noteDone at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            if (e.hp >= 0) chk("halfPeriod", hp_seen, e.hp);
            chk("rise_count", rises, e.rises);
            chk("first_rise", first_off, e.first);
            chk("done_latency", cyc - acc_cyc, e.lat);
            chk("ready_during_done", ready, 0);
            ready_chk = 1;
          end
          in_note = 0;
          done_cnt++;
        end
        if (valid && ready) begin
          in_note   = 1;
          acc_cyc   = cyc;
          rises     = 0;
          first_off = -1;
          hp_seen   = -1;
        end
      end
      prev_tone = tone;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ehp, input int erise, input int efirst, input int elat);
    exp_t e;
    e.hp = ehp; e.rises = erise; e.first = efirst; e.lat = elat;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!ready && n < bound) begin
      tick();
      n++;
    end
    if (!ready) timeout_fail("wait_noteReady");
  endtask

  task automatic wait_done(input int start, input int bound);
    int n = 0;
    while (done_cnt == start && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt == start) timeout_fail("wait_noteDone");
  endtask

  // Accept one note, then scramble the inputs to show they are latched.
  task automatic accept(input int k, input int d);
    wait_ready(50);
    key = 7'(k); dur = 12'(d); valid = 1'b1;
    tick();
    valid = 1'b0; key = 7'd0; dur = 12'd0;
  endtask

  task automatic play(input int k, input int d, input int ehp, input int erise,
                      input int efirst, input int elat);
    int s = done_cnt;
    push_exp(ehp, erise, efirst, elat);
    accept(k, d);
    wait_done(s, 2000);
  endtask

  task automatic table_check(input int k, input int ehp);
    int n = 0;
    while (!ready2 && n < 50) begin
      tick();
      n++;
    end
    if (!ready2) timeout_fail("dut2_ready");
    key2 = 7'(k); valid2 = 1'b1;
    tick();
    valid2 = 1'b0; key2 = 7'd0;
    tick();
    chk($sformatf("default_hp_key%0d", k), hp2, ehp);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("dut2_reset_ready", ready2, 1);
    chk("dut2_reset_tone", tone2, 0);
    chk("dut2_reset_hp", hp2, 0);
    chk("dut2_reset_done", done2, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n;
    rst = 1'b1; valid = 1'b0; stop = 1'b0; key = '0; dur = '0;
    rst2 = 1'b1; valid2 = 1'b0; stop2 = 1'b0; key2 = '0; dur2 = 12'd2;
    repeat (3) tick();
    rst = 1'b0; rst2 = 1'b0;
    chk("reset_ready", ready, 1);
    chk("reset_tone", tone, 0);
    chk("reset_hp", hp, 0);
    chk("reset_done", done, 0);

    // Default-parameter half-period table, each aborted by reset mid-note.
    table_check(49, 56818);
    table_check(1, 909090);
    table_check(40, 95556);
    table_check(88, 5972);
    table_check(0, 0);
    table_check(89, 0);

    // Whole notes at 100 cycles/ms: hp, rising edges, first rise offset, done latency.
    play(49, 2, 113, 1, 115, 301);
    play(88, 1, 11, 5, 13, 201);
    play(40, 2, 191, 1, 193, 301);
    play(1, 3, 1818, 0, -1, 401);
    play(2, 1, 1716, 0, -1, 201);
    play(15, 1, 809, 0, -1, 201);
    play(89, 1, 0, 0, -1, 201);
    play(100, 1, 0, 0, -1, 201);
    play(49, 0, 0, 0, -1, 101);

    // stop in IDLE is ignored
    stop = 1'b1;
    repeat (5) tick();
    chk("stop_idle_ready", ready, 1);
    stop = 1'b0;

    // stop 35 cycles into PLAY of key 88, while toneOut is high
    s = done_cnt;
    push_exp(11, 2, 13, 137);
    accept(88, 3);
    repeat (36) tick();
    chk("tone_before_stop", tone, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("tone_after_stop", tone, 0);
    wait_done(s, 2000);

    // stop during LOOKUP goes straight to GAP
    s = done_cnt;
    push_exp(-1, 0, -1, 101);
    accept(49, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(s, 2000);

    // stop during GAP is ignored
    s = done_cnt;
    push_exp(0, 0, -1, 201);
    accept(0, 1);
    repeat (150) tick();
    stop = 1'b1;
    repeat (10) tick();
    stop = 1'b0;
    wait_done(s, 2000);

    // noteValid held high with a changing key: one acceptance per IDLE visit
    s = done_cnt;
    push_exp(113, 0, -1, 201);
    push_exp(11, 5, 13, 201);
    wait_ready(50);
    key = 7'd49; dur = 12'd1; valid = 1'b1;
    tick();
    n = 0;
    while (done_cnt == s && n < 2000) begin
      key = 7'(20 + n % 60); dur = 12'(n % 7);
      tick();
      n++;
    end
    if (done_cnt == s) timeout_fail("hold_first_done");
    key = 7'd88; dur = 12'd1;
    tick();
    n = 0;
    while (done_cnt == s + 1 && n < 2000) begin
      key = 7'(3 + n % 50); dur = 12'(n % 5);
      tick();
      n++;
    end
    if (done_cnt == s + 1) timeout_fail("hold_second_done");
    valid = 1'b0;
    repeat (300) tick();
    chk("hold_done_count", done_cnt - s, 2);
    chk("hold_no_queue_ready", ready, 1);

    // reset mid-PLAY: silenced next cycle, no noteDone
    s = done_cnt;
    accept(88, 3);
    repeat (36) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_ready", ready, 1);
    chk("midreset_tone", tone, 0);
    chk("midreset_hp", hp, 0);
    repeat (400) tick();
    chk("midreset_no_done", done_cnt - s, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/note_tone_player.md
NOTE_TONE_PLAYER -- requirements
Module: note_tone_player

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, the clock rate in Hz.
REQ-002 SHALL have parameter COUNT_WIDTH, default 21, the width of the half-period counter and the halfPeriod output.
REQ-003 SHALL have parameter DUR_WIDTH, default 12, the width of the duration field in milliseconds.
REQ-004 SHALL have parameter GAP_MS, default 1, the silent gap in milliseconds inserted after every note.
REQ-005 SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-006 SHALL have port clock, input, 1 bit: the system clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port key, input, 7 bits: piano key number; 1 = A0 through 88 = C8; any other value is a rest.
REQ-009 SHALL have port duration, input, DUR_WIDTH bits: note length in ms.
REQ-010 SHALL have port noteValid, input, 1 bit: the request strobe.
REQ-011 SHALL have port stop, input, 1 bit: aborts the current note.
REQ-012 SHALL have port noteReady, output, 1 bit: high when a note can be accepted.
REQ-013 SHALL have port toneOut, output, 1 bit: the square-wave audio output.
REQ-014 SHALL have port halfPeriod, output, COUNT_WIDTH bits: the active half-period in clock cycles.
REQ-015 SHALL have port noteDone, output, 1 bit: a one-cycle pulse at the end of a note.

Function
REQ-016 SHALL hold a 12-entry base table of half-periods for keys 1..12, computed at elaboration with integer arithmetic as (CLOCK_FREQUENCY*500)/mHz.
REQ-017 The mHz values for REQ-016 SHALL be 27500, 29135, 30868, 32703, 34648, 36708, 38891, 41203, 43654, 46249, 48999 and 51913.
REQ-018 For a valid key k, halfPeriod SHALL equal base[(k-1) mod 12] >> ((k-1) div 12), i.e. a logical right shift by the octave index; no division hardware is used.
REQ-019 SHALL implement the states IDLE, LOOKUP, PLAY and GAP.
REQ-020 noteReady SHALL be 1 only in IDLE; a request is accepted on a cycle where noteValid && noteReady; accepting latches key and duration and moves to LOOKUP.
REQ-021 LOOKUP SHALL last exactly 1 cycle: it registers halfPeriod (0 for a rest), clears the tone and ms counters, and moves to PLAY.
REQ-022 A 1-ms tick SHALL be derived from a prescaler of CLOCK_FREQUENCY/1000 cycles, and the prescaler SHALL restart on entry to PLAY and to GAP.
REQ-023 In PLAY with halfPeriod != 0, the tone counter SHALL increment each cycle; when it reaches halfPeriod-1, toneOut SHALL toggle and the counter SHALL clear.
REQ-024 The first toggle SHALL occur halfPeriod cycles after PLAY entry, and toneOut SHALL start at 0.
REQ-025 For a rest, toneOut SHALL be held at 0 for the whole duration.
REQ-026 PLAY SHALL end after duration ms ticks; the FSM then forces toneOut to 0, clears halfPeriod, and enters GAP.
REQ-027 GAP SHALL last GAP_MS ticks with toneOut=0; noteDone SHALL pulse for 1 cycle on the GAP->IDLE transition.
REQ-028 If duration is 0, LOOKUP SHALL go directly to GAP with no tone output.
REQ-029 If stop is asserted in LOOKUP or PLAY, the FSM SHALL go to GAP on the next cycle with toneOut=0.
REQ-030 stop SHALL be ignored in IDLE and GAP.
REQ-031 If stop and the final ms tick occur in the same cycle, the FSM SHALL take a single transition to GAP.
REQ-032 noteValid asserted outside IDLE SHALL be ignored, with no queueing.
REQ-033 key and duration SHALL be sampled only at acceptance; later input changes have no effect.
REQ-034 All counters SHALL be sized so they never wrap within a maximum-length note.

Reset
REQ-035 When reset is high on a clock edge, the FSM SHALL return to IDLE, and reset SHALL override noteValid and stop.
REQ-036 On reset, outputs SHALL become noteReady=1, toneOut=0, halfPeriod=0 and noteDone=0, and all counters and latched fields SHALL clear.
REQ-037 Reset asserted mid-PLAY SHALL silence the output on the next cycle, and no noteDone SHALL be generated.

Verification
REQ-038 Key 49, duration 2 at default parameters -> halfPeriod=56818 from cycle 2 after acceptance; first toggle 56818 cycles after PLAY entry; PLAY lasts 100000 cycles; noteDone pulses 50000 cycles after PLAY ends.
REQ-039 Key 1 -> halfPeriod=909090; key 40 -> 95556; key 88 -> 5972; key 0 and key 89 -> halfPeriod=0 and toneOut=0 for the full duration.
REQ-040 Duration 0 with key 49 -> no toneOut toggle; noteDone 50000 cycles after LOOKUP; noteReady returns the cycle after noteDone.
REQ-041 stop pulse 10000 cycles into PLAY of key 88 -> toneOut=0 on the next cycle; GAP of 50000 cycles; single noteDone pulse.
REQ-042 noteValid held continuously with changing key -> exactly one acceptance per IDLE visit, each using the key present at its acceptance cycle.
REQ-043 Reset asserted mid-PLAY -> next cycle noteReady=1, toneOut=0, halfPeriod=0, and no noteDone pulse.
